// File: rtl/add_sub_pkg.sv
// Shared constants and types for the pipelined adder/subtractor.
package add_sub_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

endpackage

// File: rtl/add_sub_chunk.sv
// Chunk-width ripple adder; also exposes the carry into its MSB for overflow detection.
module add_sub_chunk #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o,
    output logic          cmsb_o
);

    logic [CW:0] ripple;

    always_comb begin
        ripple[0] = c_i;
        s_o       = '0;
        for (int i = 0; i < CW; i++) begin
            s_o[i]      = a_i[i] ^ b_i[i] ^ ripple[i];
            ripple[i+1] = (a_i[i] & b_i[i]) | (ripple[i] & (a_i[i] ^ b_i[i]));
        end
        c_o    = ripple[CW];
        cmsb_o = ripple[CW-1];
    end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined add/subtract with valid/ready handshake; carry chain split into STAGES chunks.
// Optional accumulator feature enabled by defining ADD_SUB_PIPE_ACC_EN.
module add_sub_pipe
    import add_sub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADD_SUB_PIPE_ACC_EN
    input  logic             acc_sel,
    input  logic             acc_clr,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             v,
    output logic             z,
    output logic             n
);

    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  opA_q [STAGES];
    logic [WIDTH-1:0]  opA_d [STAGES];
    logic [WIDTH-1:0]  opB_q [STAGES];
    logic [WIDTH-1:0]  opB_d [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];
    logic              msbCarry_q, msbCarry_d;

    logic [WIDTH-1:0]  stageA   [STAGES];
    logic [WIDTH-1:0]  stageB   [STAGES];
    logic [WIDTH-1:0]  stageSum [STAGES];
    logic [STAGES-1:0] stageCin;
    logic [STAGES-1:0] chunkCout;
    logic [STAGES-1:0] chunkCmsb;
    logic [WIDTH-1:0]  chunkSum;

    logic [WIDTH-1:0]  aEff;
    logic              hazard;
    logic              outValidRaw;
    logic              advance;
    logic              accept;
    flags_t            outFlags;
    logic              unusedBits;

`ifdef ADD_SUB_PIPE_ACC_EN
    logic [WIDTH-1:0]  acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (acc_clr)
            acc_d = '0;
        else if (out_valid && out_ready)
            acc_d = s;
    end

    always_ff @(posedge clk) begin
        if (rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    // An accumulator read must wait until no earlier result is still in flight.
    assign aEff   = acc_sel ? acc_q : a;
    assign hazard = in_valid && acc_sel && (|valid_q);
`else
    assign aEff   = a;
    assign hazard = 1'b0;
`endif

    assign outValidRaw = valid_q[STAGES-1];
    assign advance     = !(outValidRaw && !out_ready);
    assign in_ready    = !rst && advance && !hazard;
    assign accept      = in_valid && in_ready;

    always_comb begin
        stageA[0]   = aEff;
        stageB[0]   = b ^ {WIDTH{m == MODE_SUB}};
        stageSum[0] = '0;
        stageCin    = '0;
        stageCin[0] = (m == MODE_SUB);
        for (int k = 1; k < STAGES; k++) begin
            stageA[k]   = opA_q[k-1];
            stageB[k]   = opB_q[k-1];
            stageSum[k] = sum_q[k-1];
            stageCin[k] = carry_q[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_chunk
        add_sub_chunk #(.CW(CW)) u_chunk (
            .a_i    (stageA[k][k*CW +: CW]),
            .b_i    (stageB[k][k*CW +: CW]),
            .c_i    (stageCin[k]),
            .s_o    (chunkSum[k*CW +: CW]),
            .c_o    (chunkCout[k]),
            .cmsb_o (chunkCmsb[k])
        );
    end

    // Lower chunks' MSB carries and the last stage's operand copies have no consumer.
    assign unusedBits = ^chunkCmsb ^ ^opA_q[STAGES-1] ^ ^opB_q[STAGES-1];

    always_comb begin
        valid_d    = '0;
        carry_d    = chunkCout;
        msbCarry_d = chunkCmsb[STAGES-1];
        valid_d[0] = accept;
        for (int k = 1; k < STAGES; k++)
            valid_d[k] = valid_q[k-1];
        for (int k = 0; k < STAGES; k++) begin
            opA_d[k]                = stageA[k];
            opB_d[k]                = stageB[k];
            sum_d[k]                = stageSum[k];
            sum_d[k][k*CW +: CW]    = chunkSum[k*CW +: CW];
        end
    end

    // Every stage moves together, so a stall freezes the whole token train.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= '0;
            carry_q    <= '0;
            msbCarry_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= '0;
                opB_q[k] <= '0;
                sum_q[k] <= '0;
            end
        end else if (advance) begin
            valid_q    <= valid_d;
            carry_q    <= carry_d;
            msbCarry_q <= msbCarry_d;
            for (int k = 0; k < STAGES; k++) begin
                opA_q[k] <= opA_d[k];
                opB_q[k] <= opB_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    always_comb begin
        outFlags = '0;
        if (!rst) begin
            outFlags.c = carry_q[STAGES-1];
            outFlags.v = msbCarry_q ^ carry_q[STAGES-1];
            outFlags.z = (sum_q[STAGES-1] == '0);
            outFlags.n = sum_q[STAGES-1][WIDTH-1];
        end
    end

    assign out_valid = outValidRaw && !rst;
    assign s         = rst ? '0 : sum_q[STAGES-1];
    assign c_out     = outFlags.c;
    assign v         = outFlags.v;
    assign z         = outFlags.z;
    assign n         = outFlags.n;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Self-checking bench for add_sub_pipe (WIDTH=8, STAGES=2); covers ADD_SUB_PIPE_ACC_EN when defined.
module tb_add_sub_pipe;
    import add_sub_pkg::*;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst, in_valid, in_ready, m, out_valid, out_ready;
    logic         c_out, v, z, n;
    logic [W-1:0] a, b, s;
`ifdef ADD_SUB_PIPE_ACC_EN
    logic         acc_sel, acc_clr;
`endif

    int testsRun    = 0;
    int testsFailed = 0;
    int stallCycles = 0;

    typedef struct {
        logic [W-1:0] s;
        logic         c, v, z, n;
    } exp_t;

    exp_t         expQ[$];
    logic [W-1:0] resLog[$];
    logic [W-1:0] accModel = '0;

    always #5 clk = ~clk;

    add_sub_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m         (m),
        .a         (a),
        .b         (b),
`ifdef ADD_SUB_PIPE_ACC_EN
        .acc_sel   (acc_sel),
        .acc_clr   (acc_clr),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .c_out     (c_out),
        .v         (v),
        .z         (z),
        .n         (n)
    );

    // Reference result from plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic mode, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t        e;
        int unsigned ux = x;
        int unsigned uy = y;
        int          sx = $signed(x);
        int          sy = $signed(y);
        int          r;
        if (mode == MODE_ADD) begin
            e.s = W'(ux + uy);
            e.c = (ux + uy) >= (1 << W);
            r   = sx + sy;
        end else begin
            e.s = W'(ux - uy);
            e.c = (ux >= uy);
            r   = sx - sy;
        end
        e.v = (r > (2**(W-1)) - 1) || (r < -(2**(W-1)));
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [W-1:0] es,
                               input logic ec, input logic evf, input logic ez, input logic en);
        check(name, {out_valid, s, c_out, v, z, n}, {ev, es, ec, evf, ez, en});
    endtask

    // Holds the operand set until the DUT accepts it; returns 1 time unit after the accepting edge.
    task automatic applyStimulus(input logic mode, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic sel);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        m        = mode;
        a        = av;
        b        = bv;
`ifdef ADD_SUB_PIPE_ACC_EN
        acc_sel  = sel;
`endif
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL accept_timeout: in_ready never rose (a=0x%0h b=0x%0h sel=%0b)", av, bv, sel);
        end
        in_valid = 1'b0;
`ifdef ADD_SUB_PIPE_ACC_EN
        acc_sel  = 1'b0;
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (expQ.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", expQ.size(), 0);
    endtask

    task automatic runLatencyCase(input string name, input logic mode, input logic [W-1:0] av,
                                  input logic [W-1:0] bv, input logic [W-1:0] es, input logic ec,
                                  input logic evf, input logic ez, input logic en);
        applyStimulus(mode, av, bv, 1'b0);
        @(negedge clk);
        check({name, "_early"}, out_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        checkOutput(name, 1'b1, es, ec, evf, ez, en);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every cycle a result is presented it must match the oldest pending operation.
    always @(negedge clk) begin
        exp_t         e;
        logic [W-1:0] aEff;
        if (rst) begin
            expQ.delete();
            accModel = '0;
        end else begin
            aEff = a;
`ifdef ADD_SUB_PIPE_ACC_EN
            if (acc_sel)
                aEff = accModel;
`endif
            if (in_valid && in_ready)
                expQ.push_back(model(m, aEff, b));
            if (in_valid && !in_ready)
                stallCycles++;
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_result: s=0x%0h with nothing pending", s);
                end else begin
                    e = expQ[0];
                    check("result", {s, c_out, v, z, n}, {e.s, e.c, e.v, e.z, e.n});
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        resLog.push_back(s);
                        accModel = e.s;
                    end
                end
            end
`ifdef ADD_SUB_PIPE_ACC_EN
            if (acc_clr)
                accModel = '0;
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] b2bS [4] = '{8'h11, 8'h3D, 8'h10, 8'hFC};
        logic         b2bC [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic         b2bN [4] = '{1'b0, 1'b0, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b1;
        m         = MODE_ADD;
        a         = 8'h12;
        b         = 8'h34;
        out_ready = 1'b1;
`ifdef ADD_SUB_PIPE_ACC_EN
        acc_sel   = 1'b0;
        acc_clr   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("in_ready_after_reset", in_ready, 1'b1);
        check("no_valid_after_reset", out_valid, 1'b0);
        @(posedge clk);
        #1;

        runLatencyCase("add_7f_01", MODE_ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
        runLatencyCase("sub_00_01", MODE_SUB, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        runLatencyCase("sub_05_05", MODE_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        runLatencyCase("sub_80_01", MODE_SUB, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
        runLatencyCase("add_wrap",  MODE_ADD, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);

        // Four operations on consecutive cycles, results expected on consecutive cycles from +2.
        fork
            begin
                applyStimulus(MODE_ADD, 8'h10, 8'h01, 1'b0);
                applyStimulus(MODE_SUB, 8'h40, 8'h03, 1'b0);
                applyStimulus(MODE_ADD, 8'hF0, 8'h20, 1'b0);
                applyStimulus(MODE_SUB, 8'h03, 8'h07, 1'b0);
            end
            begin
                @(posedge clk);
                @(posedge clk);
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    checkOutput($sformatf("b2b_%0d", i), 1'b1, b2bS[i], b2bC[i], 1'b0, 1'b0, b2bN[i]);
                    @(posedge clk);
                end
            end
        join
        #1;
        drain();

`ifdef ADD_SUB_PIPE_ACC_EN
        acc_clr = 1'b1;
        @(posedge clk);
        #1;
        acc_clr = 1'b0;
        resLog.delete();
        stallCycles = 0;
        for (int i = 0; i < 3; i++)
            applyStimulus(MODE_ADD, 8'h55, 8'h10, 1'b1);
        drain();
        check("acc_count", resLog.size(), 3);
        check("acc_0", resLog[0], 8'h10);
        check("acc_1", resLog[1], 8'h20);
        check("acc_2", resLog[2], 8'h30);
        check("acc_interlock_stalled", stallCycles > 0, 1'b1);
`endif

        // Back-pressure with a full pipe: outputs must freeze and nothing may be lost or repeated.
        out_ready = 1'b0;
        resLog.delete();
        fork
            begin
                applyStimulus(MODE_ADD, 8'h01, 8'h02, 1'b0);
                applyStimulus(MODE_ADD, 8'h10, 8'h20, 1'b0);
                applyStimulus(MODE_SUB, 8'h09, 8'h04, 1'b0);
            end
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    seen = out_valid;
                end
                check("bp_result_appeared", seen, 1'b1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0)
                        @(negedge clk);
                    checkOutput($sformatf("bp_hold_%0d", i), 1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
                    check($sformatf("bp_in_ready_%0d", i), in_ready, 1'b0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", resLog.size(), 3);
        check("bp_order_0", resLog[0], 8'h03);
        check("bp_order_1", resLog[1], 8'h30);
        check("bp_order_2", resLog[2], 8'h05);

        // Reset with two operations in flight.
        applyStimulus(MODE_ADD, 8'h22, 8'h11, 1'b0);
        applyStimulus(MODE_SUB, 8'h44, 8'h01, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_outputs", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid_in_ready", in_ready, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready_after", in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("rst_mid_no_stale_%0d", i), out_valid, 1'b0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        runLatencyCase("after_rst", MODE_SUB, 8'h20, 8'h30, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (WIDTH >= 2).
REQ-002 SHALL have parameter STAGES, default 2, meaning number of pipeline stages (1..WIDTH, WIDTH divisible by STAGES).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1, meaning the operand set is valid.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts an operand set this cycle.
REQ-007 SHALL have port m, input, 1, meaning mode: 0 = A+B, 1 = A-B.
REQ-008 SHALL have ports a and b, input, WIDTH each, meaning the operands (two's complement or unsigned).
REQ-009 SHALL have port out_valid, output, 1, meaning the result is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes the result.
REQ-011 SHALL have port s, output, WIDTH, meaning the result.
REQ-012 SHALL have ports c_out, v, z, n, output, 1 each, meaning carry-out, signed overflow, zero, and negative flags.

Function
REQ-013 SHALL accept an operand set on a cycle with in_valid && in_ready, and a result SHALL transfer on a cycle with out_valid && out_ready.
REQ-014 SHALL compute a + (b XOR {WIDTH{m}}) + m, with a carry chain split into STAGES chunks of WIDTH/STAGES bits, LSB chunk first, so that stage k adds chunk k using the registered carry from stage k-1.
REQ-015 SHALL skew-register unprocessed upper chunks and completed lower chunks so that each operation travels as one token; result latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall.
REQ-016 SHALL sustain one operation per cycle while out_ready=1; bubbles SHALL propagate and SHALL NOT be collapsed.
REQ-017 SHALL stall the whole pipeline when out_valid && !out_ready; in_ready SHALL be !(out_valid && !out_ready), and s and all flags SHALL hold stable during a stall.
REQ-018 SHALL drive c_out as the carry out of the MSB (for subtract, 1 = no borrow), v as the carry into the MSB XOR the carry out of the MSB, z as (s == 0), and n as s[WIDTH-1].
REQ-019 SHALL wrap the result modulo 2^WIDTH; no saturation.

Reset
REQ-020 SHALL, while rst=1, clear all stage valid bits, drive out_valid=0, s=0, and c_out=v=z=n=0, and drive in_ready=0; in-flight operations SHALL be discarded.
REQ-021 SHALL assert in_ready on the first cycle after rst deasserts, and ignore in_valid during reset.

Configuration
REQ-022 SHALL, when macro ADD_SUB_PIPE_ACC_EN is defined, add inputs acc_sel and acc_clr (1 bit each) and an internal WIDTH-bit accumulator, reset to 0.
REQ-023 SHALL, with ADD_SUB_PIPE_ACC_EN, use the accumulator in place of a when acc_sel=1, and load the accumulator with s on every result transfer.
REQ-024 SHALL, with ADD_SUB_PIPE_ACC_EN, hold in_ready=0 while in_valid && acc_sel and any stage holds a valid operation (read-after-write interlock).
REQ-025 SHALL, with ADD_SUB_PIPE_ACC_EN, clear the accumulator when acc_clr=1, with acc_clr taking priority over a coincident result load.
REQ-026 SHALL, without ADD_SUB_PIPE_ACC_EN, have neither the accumulator nor the acc_sel/acc_clr ports, with behaviour per REQ-013..021.

Structure
REQ-027 SHALL take mode constants (MODE_ADD=0, MODE_SUB=1) and a flags struct {c, v, z, n} from the shared package add_sub_pkg.
REQ-028 SHALL implement each chunk with one sub-module, add_sub_chunk (chunk-width ripple adder, carry in/out, carry into the chunk MSB exposed for v).

Verification
REQ-029 SHALL verify WIDTH=8, STAGES=2: m=0, a=0x7F, b=0x01 -> after 2 cycles s=0x80, v=1, n=1, c_out=0, z=0.
REQ-030 SHALL verify m=1: 0x00-0x01 -> s=0xFF, c_out=0, v=0, n=1; 0x05-0x05 -> s=0x00, c_out=1, z=1; 0x80-0x01 -> s=0x7F, v=1, c_out=1.
REQ-031 SHALL verify back-to-back: 4 ops on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles, in order, first at +2.
REQ-032 SHALL verify backpressure: out_ready=0 for 3 cycles with the pipe full -> in_ready=0, s and flags stable, no loss or duplication on release.
REQ-033 SHALL verify reset mid-operation: rst for 1 cycle with 2 ops in flight -> out_valid=0, outputs 0, no stale result afterwards.
REQ-034 SHALL verify, with ADD_SUB_PIPE_ACC_EN: acc_clr, then 3 ops acc_sel=1, m=0, b=0x10 -> results 0x10, 0x20, 0x30, with in_ready stalls per REQ-024.
